muldiv_sequencer: RTL and testbench

- Multi-cycle controller that executes MIPS MULTU and DIVU by time-sharing the 32-bit combinational ALU: one ALU add or subtract per iteration, 32 iterations per operation.
- Holds the HI/LO result registers and sits beside the main ALU in the execute stage.
- The datapath mux giving this block ALU ownership while busy=1 lives outside the block.

---
 rtl/muldiv_sequencer_if.sv | 33 +++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: bundles the signals between the execute stage and the
// MULTU/DIVU sequencer.
//   Request side : start, op (0 = MULTU, 1 = DIVU), operand_a, operand_b
//   ALU side     : alu_a, alu_b, alu_ctrl out to the shared ALU, alu_result back
//   Result side  : busy, done, hi, lo, div_by_zero
// The master modport is the pipeline/ALU side; the slave modport is the sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, alu_result,
        input  alu_a, alu_b, alu_ctrl, busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, alu_result,
        output alu_a, alu_b, alu_ctrl, busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: executes MIPS MULTU / DIVU over WIDTH cycles by borrowing
// the main combinational ALU for one add (multiply) or subtract (divide) per
// iteration. Owns the HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of muldiv_sequencer_if (request, ALU, results)
// busy is high whenever the sequencer is not IDLE; the external datapath mux
// uses it to hand the ALU operands over to this block.
module muldiv_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] ALU_ADD  = 4'b0010,
    parameter logic [3:0] ALU_SUB  = 4'b0110,
    parameter logic [3:0] ALU_IDLE = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;       // multiplicand (MUL) or divisor (DIV)
    logic [CNT_W-1:0] count_q;
    logic             done_q;
    logic             busy_q;
    logic             dbz_q;

    logic [WIDTH-1:0] div_s;     // partial remainder shifted left by one
    logic             div_msb;   // bit shifted out of hi; forces a subtract
    logic             mul_carry;
    logic             div_borrow;
    logic             last_iter;

    // Carry out of an unsigned add, rebuilt from the operand and sum MSBs.
    function automatic logic add_carry(input logic a_msb, input logic b_msb,
                                       input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

    // Borrow out of an unsigned subtract, rebuilt from the operand and difference MSBs.
    function automatic logic sub_borrow(input logic a_msb, input logic b_msb,
                                        input logic diff_msb);
        return (~a_msb & b_msb) | (~(a_msb ^ b_msb) & diff_msb);
    endfunction

    assign div_s      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign div_msb    = hi_q[WIDTH-1];
    assign mul_carry  = add_carry(hi_q[WIDTH-1], m_q[WIDTH-1], bus.alu_result[WIDTH-1]);
    assign div_borrow = sub_borrow(div_s[WIDTH-1], m_q[WIDTH-1], bus.alu_result[WIDTH-1]);
    assign last_iter  = (count_q == CNT_W'(WIDTH - 1));

    // ALU request, decoded from registered state only.
    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ALU_IDLE;
        case (state)
            S_MUL: begin
                bus.alu_a    = hi_q;
                bus.alu_b    = m_q;
                bus.alu_ctrl = ALU_ADD;
            end
            S_DIV: begin
                bus.alu_a    = div_s;
                bus.alu_b    = m_q;
                bus.alu_ctrl = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        if (!bus.op) begin
                            hi_q  <= '0;
                            lo_q  <= bus.operand_b;
                            m_q   <= bus.operand_a;
                            state <= S_MUL;
                        end else if (bus.operand_b != '0) begin
                            hi_q  <= '0;
                            lo_q  <= bus.operand_a;
                            m_q   <= bus.operand_b;
                            state <= S_DIV;
                        end else begin
                            // Divide by zero: MIPS-style result with no iterations.
                            hi_q   <= bus.operand_a;
                            lo_q   <= '1;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    count_q <= count_q + CNT_W'(1);
                    if (lo_q[0])
                        {hi_q, lo_q} <= {mul_carry, bus.alu_result, lo_q[WIDTH-1:1]};
                    else
                        {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
                    if (last_iter) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DIV: begin
                    count_q <= count_q + CNT_W'(1);
                    // A set msb means the shifted remainder already exceeds D.
                    if (div_msb | ~div_borrow) begin
                        hi_q <= bus.alu_result;
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_q <= div_s;
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end
                    if (last_iter) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random stimulus for muldiv_sequencer,
// checked every cycle against a countdown/arithmetic reference model, plus
// literal expectations for the directed cases.
module tb_muldiv_sequencer;
    localparam int         W        = 32;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(
        .WIDTH(W), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB), .ALU_IDLE(ALU_IDLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural stand-in for the shared execute-stage ALU.
    assign bus.alu_result = (bus.alu_ctrl == ALU_ADD) ? bus.alu_a + bus.alu_b :
                            (bus.alu_ctrl == ALU_SUB) ? bus.alu_a - bus.alu_b :
                                                        bus.alu_a & bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an operation is pending for a fixed number of edges,
    // after which the arithmetic result appears with a one-cycle done.
    logic          mv;
    logic          exp_busy, exp_done, exp_dbz, exp_op;
    logic [W-1:0]  exp_hi, exp_lo, pend_hi, pend_lo;
    int            left;
    logic [2*W-1:0] prod;

    initial begin
        mv = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_dbz = 1'b0; exp_op = 1'b0;
        exp_hi = '0; exp_lo = '0; pend_hi = '0; pend_lo = '0; left = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            mv <= 1'b1; exp_busy <= 1'b0; exp_done <= 1'b0; exp_dbz <= 1'b0;
            exp_hi <= '0; exp_lo <= '0; left <= 0;
        end else if (!exp_busy) begin
            if (bus.start) begin
                exp_op   <= bus.op;
                exp_busy <= 1'b1;
                if (bus.op && bus.operand_b == '0) begin
                    exp_hi   <= bus.operand_a;
                    exp_lo   <= '1;
                    exp_dbz  <= 1'b1;
                    exp_done <= 1'b1;
                end else begin
                    exp_dbz <= 1'b0;
                    left    <= W;
                    if (bus.op) begin
                        pend_hi <= bus.operand_a % bus.operand_b;
                        pend_lo <= bus.operand_a / bus.operand_b;
                    end else begin
                        prod = (2*W)'(bus.operand_a) * (2*W)'(bus.operand_b);
                        pend_hi <= prod[2*W-1:W];
                        pend_lo <= prod[W-1:0];
                    end
                end
            end
        end else if (exp_done) begin
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else begin
            left <= left - 1;
            if (left == 1) begin
                exp_done <= 1'b1;
                exp_hi   <= pend_hi;
                exp_lo   <= pend_lo;
            end
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            chk("done", 64'(bus.done), 64'(exp_done));
            chk("div_by_zero", 64'(bus.div_by_zero), 64'(exp_dbz));
            if (!exp_busy || exp_done) begin
                chk("hi", 64'(bus.hi), 64'(exp_hi));
                chk("lo", 64'(bus.lo), 64'(exp_lo));
                chk("alu_ctrl_idle", 64'(bus.alu_ctrl), 64'(ALU_IDLE));
                chk("alu_a_idle", 64'(bus.alu_a), 64'(0));
                chk("alu_b_idle", 64'(bus.alu_b), 64'(0));
            end else begin
                chk("alu_ctrl_iter", 64'(bus.alu_ctrl), 64'(exp_op ? ALU_SUB : ALU_ADD));
            end
        end
    end

    // Issue one operation, scramble the operands while busy, and check the
    // result against hand-computed values and the done latency.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ed, input int elat);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(elat));
        chk("lit_hi", 64'(bus.hi), 64'(eh));
        chk("lit_lo", 64'(bus.lo), 64'(el));
        chk("lit_dbz", 64'(bus.div_by_zero), 64'(ed));
        @(negedge clk);
        chk("lit_busy_after", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int n;
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_hi", 64'(bus.hi), 64'(0));
        chk("reset_lo", 64'(bus.lo), 64'(0));

        do_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 32);
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
        do_op(1'b0, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0, 32);
        do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        do_op(1'b1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 32);
        do_op(1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 32);
        do_op(1'b1, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF, 1'b1, 0);
        do_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 32);

        // Start pulses at iteration 10 and in the DONE cycle are ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'h1234; bus.operand_b = 32'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 32'd99; bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ign_done", 64'(bus.done), 64'(1));
        chk("ign_lo", 64'(bus.lo), 64'(32'h12340));
        chk("ign_hi", 64'(bus.hi), 64'(0));
        bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd7; bus.operand_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            chk("ign_no_second_done", 64'(bus.done), 64'(0));
            chk("ign_idle", 64'(bus.busy), 64'(0));
            @(negedge clk);
        end

        // Reset in the middle of a multiply.
        bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'hDEAD; bus.operand_b = 32'hBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        chk("rst_mid_done", 64'(bus.done), 64'(0));
        chk("rst_mid_hi", 64'(bus.hi), 64'(0));
        chk("rst_mid_lo", 64'(bus.lo), 64'(0));
        do_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 32);

        // Random traffic, including start while busy and rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 799) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 1'($urandom_range(0, 1));
            bus.operand_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 7))
                0:       bus.operand_b = '0;
                1:       bus.operand_b = 32'($urandom_range(1, 15));
                2:       bus.operand_b = 32'h80000000 | $urandom;
                default: bus.operand_b = $urandom;
            endcase
        end
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
